bi_stream_to_binary: RTL and testbench



---
 rtl/stream_pkg.sv | 15 +
 rtl/bi_stream_to_binary_if.sv | 24 ++
 rtl/bi_stream_to_binary_ones_window_counter.sv | 36 +++
 rtl/bi_stream_to_binary.sv | 90 +++++++++
 tb/tb_bi_stream_to_binary.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the bipolar stream-to-binary path.
// Holds the window FSM state encoding and the bipolar result offset.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic int result_offset(input int width);
        return 32'sd1 << (width - 32'sd1);
    endfunction

endpackage

// File: rtl/bi_stream_to_binary_if.sv
// Handshake bundle between a bipolar bitstream source, the window counter
// and the consumer of the signed binary result.
interface bi_stream_to_binary_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, in, in_valid, out_ready,
        input  in_ready, out, out_valid, busy
    );

    modport slave (
        input  start, in, in_valid, out_ready,
        output in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/bi_stream_to_binary_ones_window_counter.sv
// Sample and ones counters for one window of 2^WIDTH accepted samples.
// The sample counter wraps to zero naturally on the last accepted sample.
module ones_window_counter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           bit_in,
    output logic [WIDTH:0] ones,
    output logic           last
);
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH:0]   ones_r;

    // Count accepted samples and the ones among them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {WIDTH{1'b0}};
            ones_r <= {(WIDTH+1){1'b0}};
        end else if (clr) begin
            cnt_r  <= {WIDTH{1'b0}};
            ones_r <= {(WIDTH+1){1'b0}};
        end else if (en) begin
            cnt_r  <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
            ones_r <= ones_r + {{WIDTH{1'b0}}, bit_in};
        end else begin
            cnt_r  <= cnt_r;
            ones_r <= ones_r;
        end
    end

    assign ones = ones_r;
    assign last = (cnt_r == {WIDTH{1'b1}});
endmodule

// File: rtl/bi_stream_to_binary.sv
// Converts a bipolar unary bitstream into a signed binary value over a
// window of 2^WIDTH accepted samples, returned through valid/ready.
module bi_stream_to_binary
    import stream_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    bi_stream_to_binary_if.slave   bus
);
    localparam logic [WIDTH:0] OFFSET = (WIDTH+1)'(result_offset(WIDTH));

    state_e          state_r;
    state_e          state_s;
    logic            accept_s;
    logic            last_s;
    logic            win_done_s;
    logic [WIDTH:0]  ones_s;
    logic [WIDTH:0]  out_r;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            busy_r;

    assign accept_s   = bus.in_valid && in_ready_r;
    assign win_done_s = (state_r == ACC) && accept_s && last_s;

    // Counters stay cleared whenever no window is being accumulated.
    ones_window_counter #(.WIDTH(WIDTH)) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_r != ACC),
        .en     (accept_s),
        .bit_in (bus.in),
        .ones   (ones_s),
        .last   (last_s)
    );

    // Window FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = ACC;
                else           state_s = IDLE;
            end
            ACC: begin
                if (win_done_s) state_s = HOLD;
                else            state_s = ACC;
            end
            HOLD: begin
                if (bus.out_ready) state_s = CONTINUOUS ? ACC : IDLE;
                else               state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, decoded status flags and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_r       <= {(WIDTH+1){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == ACC);
            busy_r     <= (state_s != IDLE);
            // The final sample is folded in directly; ones_s lags it by one edge.
            if (win_done_s) begin
                out_r       <= ones_s + {{WIDTH{1'b0}}, bus.in} - OFFSET;
                out_valid_r <= 1'b1;
            end else if ((state_r == HOLD) && bus.out_ready) begin
                out_r       <= out_r;
                out_valid_r <= 1'b0;
            end else begin
                out_r       <= out_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_bi_stream_to_binary.sv
// Directed scoreboard bench for bi_stream_to_binary with WIDTH=4, one
// instance per CONTINUOUS setting; sel chooses which instance is driven.
module tb_bi_stream_to_binary;
    logic clk = 1'b0;
    logic rst;
    logic st, din, dv, ordy;
    bit   sel;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] q[$];

    always #5 clk = ~clk;

    bi_stream_to_binary_if #(.WIDTH(4)) b0 ();
    bi_stream_to_binary_if #(.WIDTH(4)) b1 ();

    assign b0.start     = st & ~sel;
    assign b0.in        = din;
    assign b0.in_valid  = dv & ~sel;
    assign b0.out_ready = ordy & ~sel;
    assign b1.start     = st & sel;
    assign b1.in        = din;
    assign b1.in_valid  = dv & sel;
    assign b1.out_ready = ordy & sel;

    logic [4:0] obs_out;
    logic       obs_valid, obs_ready, obs_busy;
    assign obs_out   = sel ? b1.out       : b0.out;
    assign obs_valid = sel ? b1.out_valid : b0.out_valid;
    assign obs_ready = sel ? b1.in_ready  : b0.in_ready;
    assign obs_busy  = sel ? b1.busy      : b0.busy;

    bi_stream_to_binary #(.WIDTH(4), .CONTINUOUS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    bi_stream_to_binary #(.WIDTH(4), .CONTINUOUS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [15:0] p);
        logic [4:0] ones;
        ones = 5'($countones(p));
        return ones - 5'd8;
    endfunction

    task automatic start_win();
        st = 1'b1;
        tick();
        st = 1'b0;
        check("start_busy", {31'd0, obs_busy}, 32'd1);
        check("start_in_ready", {31'd0, obs_ready}, 32'd1);
    endtask

    // Presents pat bit by bit until n samples are accepted.
    task automatic feed(input logic [15:0] pat, input int n, input bit gaps,
                        input bit pulse, output int cycles);
        int  acc = 0;
        int  cyc = 0;
        bit  took;
        if (n == 16) q.push_back(model(pat));
        while (acc < n && cyc < 200) begin
            dv  = !(gaps && (cyc % 3 == 2));
            din = pat[acc];
            st  = pulse && (cyc == 4);
            took = dv && obs_ready;
            if (took && acc == 15) check("valid_before_last", {31'd0, obs_valid}, 32'd0);
            tick();
            cyc++;
            if (took) acc++;
        end
        dv = 1'b0;
        st = 1'b0;
        check("feed_accepted", acc, n);
        if (n == 16) check("valid_after_last", {31'd0, obs_valid}, 32'd1);
        cycles = cyc;
    endtask

    // Pops the expected result and hands the output through the handshake.
    task automatic collect(input int hold, input bit with_start);
        logic [4:0] exp;
        int w = 0;
        while (!obs_valid && w < 50) begin
            tick();
            w++;
        end
        check("result_valid", {31'd0, obs_valid}, 32'd1);
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
            exp = 5'd0;
        end else begin
            exp = q.pop_front();
        end
        repeat (hold) begin
            check("hold_out", {27'd0, obs_out}, {27'd0, exp});
            check("hold_valid", {31'd0, obs_valid}, 32'd1);
            check("hold_in_ready", {31'd0, obs_ready}, 32'd0);
            check("hold_busy", {31'd0, obs_busy}, 32'd1);
            tick();
        end
        ordy = 1'b1;
        st   = with_start;
        check("result_out", {27'd0, obs_out}, {27'd0, exp});
        tick();
        ordy = 1'b0;
        st   = 1'b0;
        check("after_valid", {31'd0, obs_valid}, 32'd0);
        check("after_busy", {31'd0, obs_busy}, {31'd0, sel});
        check("after_in_ready", {31'd0, obs_ready}, {31'd0, sel});
    endtask

    initial begin
        int cyc;
        sel = 1'b0; rst = 1'b1; st = 1'b0; din = 1'b0; dv = 1'b0; ordy = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            sel = (k == 1);
            check("rst_out", {27'd0, obs_out}, 32'd0);
            check("rst_valid", {31'd0, obs_valid}, 32'd0);
            check("rst_in_ready", {31'd0, obs_ready}, 32'd0);
            check("rst_busy", {31'd0, obs_busy}, 32'd0);
        end
        sel = 1'b0;
        rst = 1'b0;
        tick();

        // All ones: +8.
        start_win();
        feed(16'hFFFF, 16, 1'b0, 1'b0, cyc);
        collect(2, 1'b0);

        // All zeros: -8, single-cycle valid with ready already high.
        start_win();
        feed(16'h0000, 16, 1'b0, 1'b0, cyc);
        collect(0, 1'b0);

        // Alternating with valid gaps: 0, more than 16 cycles.
        start_win();
        feed(16'h5555, 16, 1'b1, 1'b0, cyc);
        check("gap_cycles_gt16", {31'd0, cyc > 16}, 32'd1);
        collect(1, 1'b0);

        // Converter output (u1 | u2 of two 50% streams) plus start pulses.
        start_win();
        feed(16'hAAAA | 16'hCCCC, 16, 1'b0, 1'b1, cyc);
        check("conv_near_plus4", {31'd0, ($signed(obs_out) >= 5'sd2) && ($signed(obs_out) <= 5'sd6)}, 32'd1);
        st = 1'b1;
        tick();
        st = 1'b0;
        check("hold_start_valid", {31'd0, obs_valid}, 32'd1);
        collect(1, 1'b1);
        tick();
        check("start_not_latched", {31'd0, obs_busy}, 32'd0);

        // Reset mid-window, then 1,1,1,0 pattern: +4.
        start_win();
        feed(16'hFFFF, 7, 1'b0, 1'b0, cyc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out", {27'd0, obs_out}, 32'd0);
        check("mid_rst_valid", {31'd0, obs_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, obs_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, obs_busy}, 32'd0);
        start_win();
        feed(16'h7777, 16, 1'b0, 1'b0, cyc);
        collect(0, 1'b0);

        // Continuous instance under backpressure, then an automatic second window.
        sel = 1'b1;
        start_win();
        feed(16'h00FF, 16, 1'b0, 1'b0, cyc);
        collect(5, 1'b0);
        feed(16'h1111, 16, 1'b0, 1'b0, cyc);
        collect(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
